// File: rtl/ov7670_capture.sv
`timescale 1ns/1ps
// ov7670_capture
// Samples the OV7670 parallel bus in the clk24 domain, assembles two bytes
// per pixel, reduces each pixel to 4-bit grayscale and writes it into the
// shared frame buffer at a linear raster address (0 .. H_PIX*V_PIX-1).
//
// Build option: define CAPTURE_RGB565_EN to treat pixels as RGB565
// (gray = (R5+G6+B5)>>3). Without it the bus is YUYV, Y byte first, and
// gray = Y[7:4].
//
// Ports
//   clk24       in   24 MHz system clock
//   rst_n       in   asynchronous active-low reset
//   cam_pclk    in   camera pixel clock (async, <= 12 MHz)
//   cam_href    in   camera line valid
//   cam_vsync   in   camera frame sync (high between frames)
//   cam_d[7:0]  in   camera data byte
//   wr_addr     out  frame-buffer write address
//   wr_data     out  4-bit grayscale pixel
//   wr_en       out  one-cycle write strobe
//   frame_done  out  one-cycle pulse on leaving an active frame
//   frame_ovf   out  sticky: frame carried more than H_PIX*V_PIX pixels
//   capturing   out  high while the capture FSM is ACTIVE
module ov7670_capture #(
   parameter int H_PIX = 640,
   parameter int V_PIX = 480
) (
   input  logic        clk24,
   input  logic        rst_n,
   input  logic        cam_pclk,
   input  logic        cam_href,
   input  logic        cam_vsync,
   input  logic [7:0]  cam_d,
   output logic [18:0] wr_addr,
   output logic [3:0]  wr_data,
   output logic        wr_en,
   output logic        frame_done,
   output logic        frame_ovf,
   output logic        capturing
);

   localparam logic [18:0] LIMIT = 19'(H_PIX * V_PIX);

   typedef enum logic [1:0] {S_IDLE, S_VSYNC, S_ACTIVE} state_t;

   state_t      r_state, w_state_nxt;

   logic        r_pclk_s1, r_pclk_s2, r_pclk_s3;
   logic        r_href_s1, r_href_s2;
   logic        r_vs_s1,   r_vs_s2,   r_vs_s3;
   logic [7:0]  r_d_s1,    r_d_s2;

   logic        r_phase;
   logic        r_pix_vld;
   logic [7:0]  r_byte0;
`ifdef CAPTURE_RGB565_EN
   logic [7:0]  r_byte1;
   logic [6:0]  w_y;
`endif
   logic [18:0] r_pix_cnt;
   logic [3:0]  w_pix;

   logic        w_pclk_rise, w_vs_rise, w_vs_fall, w_vs_evt;

   // Two-flop synchronisers; pclk and vsync get a third flop for edges.
   always_ff @(posedge clk24 or negedge rst_n) begin
      if (!rst_n) begin
         r_pclk_s1 <= 1'b0; r_pclk_s2 <= 1'b0; r_pclk_s3 <= 1'b0;
         r_href_s1 <= 1'b0; r_href_s2 <= 1'b0;
         r_vs_s1   <= 1'b0; r_vs_s2   <= 1'b0; r_vs_s3   <= 1'b0;
         r_d_s1    <= 8'd0; r_d_s2    <= 8'd0;
      end else begin
         r_pclk_s1 <= cam_pclk;  r_pclk_s2 <= r_pclk_s1; r_pclk_s3 <= r_pclk_s2;
         r_href_s1 <= cam_href;  r_href_s2 <= r_href_s1;
         r_vs_s1   <= cam_vsync; r_vs_s2   <= r_vs_s1;   r_vs_s3   <= r_vs_s2;
         r_d_s1    <= cam_d;     r_d_s2    <= r_d_s1;
      end
   end

   assign w_pclk_rise = r_pclk_s2 & ~r_pclk_s3;
   assign w_vs_rise   = r_vs_s2 & ~r_vs_s3;
   assign w_vs_fall   = ~r_vs_s2 & r_vs_s3;
   assign w_vs_evt    = w_vs_rise | w_vs_fall;

   // Grayscale reduction of the assembled pixel.
`ifdef CAPTURE_RGB565_EN
   assign w_y   = 7'(r_byte0[7:3]) + 7'({r_byte0[2:0], r_byte1[7:5]}) + 7'(r_byte1[4:0]);
   assign w_pix = 4'(w_y >> 3);
`else
   assign w_pix = 4'(r_byte0 >> 4);
`endif

   // Frame FSM: state register.
   always_ff @(posedge clk24 or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Frame FSM: next state. Capture only ever begins on a vsync fall seen
   // after a vsync rise, so a frame already in flight at reset is skipped.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_vs_rise) w_state_nxt = S_VSYNC;
         S_VSYNC:  if (w_vs_fall) w_state_nxt = S_ACTIVE;
         S_ACTIVE: if (w_vs_rise) w_state_nxt = S_VSYNC;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Byte assembly, pixel counting and the registered write port.
   // A completed pixel is flagged in r_pix_vld one cycle before the write
   // strobe so the conversion sees both stable byte registers.
   always_ff @(posedge clk24 or negedge rst_n) begin
      if (!rst_n) begin
         r_phase    <= 1'b0;
         r_pix_vld  <= 1'b0;
         r_byte0    <= 8'd0;
`ifdef CAPTURE_RGB565_EN
         r_byte1    <= 8'd0;
`endif
         r_pix_cnt  <= 19'd0;
         wr_addr    <= 19'd0;
         wr_data    <= 4'd0;
         wr_en      <= 1'b0;
         frame_done <= 1'b0;
         frame_ovf  <= 1'b0;
         capturing  <= 1'b0;
      end else begin
         r_pix_vld  <= 1'b0;
         wr_en      <= 1'b0;
         frame_done <= 1'b0;
         capturing  <= (w_state_nxt == S_ACTIVE);

         if (r_state == S_ACTIVE && w_vs_rise) frame_done <= 1'b1;

         if (r_state == S_VSYNC && w_vs_fall) begin
            r_pix_cnt <= 19'd0;
            frame_ovf <= 1'b0;
            r_phase   <= 1'b0;
         end else begin
            // A vsync edge in the same cycle as a pclk rise drops that byte.
            if (r_state == S_ACTIVE && !w_vs_evt) begin
               if (!r_href_s2) begin
                  r_phase <= 1'b0;
               end else if (w_pclk_rise) begin
                  r_phase <= ~r_phase;
                  if (!r_phase) begin
                     r_byte0 <= r_d_s2;
                  end else begin
`ifdef CAPTURE_RGB565_EN
                     r_byte1 <= r_d_s2;
`endif
                     r_pix_vld <= 1'b1;
                  end
               end
            end

            if (r_pix_vld) begin
               if (r_pix_cnt < LIMIT) begin
                  wr_en     <= 1'b1;
                  wr_addr   <= r_pix_cnt;
                  wr_data   <= w_pix;
                  r_pix_cnt <= r_pix_cnt + 19'd1;
               end else begin
                  // Saturated: drop the pixel, never wrap into address 0.
                  frame_ovf <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: doc/ov7670_capture.md
# ov7670_capture

Camera-side capture stage that feeds the shared 640x480x4-bit frame buffer, which the VGA output stage reads. It samples the OV7670 parallel bus (cam_pclk, cam_href, cam_vsync, cam_d) in the clk24 domain, assembles two bytes per pixel and reduces each pixel to 4-bit grayscale. It writes one word per pixel at a linear address from 0 to 640*480-1, using the same raster order the VGA stage reads in. The camera runs with cam_pclk at or below 12 MHz, so oversampling at clk24 is valid.

## Interface
Parameters:
- H_PIX, 640, pixels per line.
- V_PIX, 480, lines per frame; the address limit is H_PIX*V_PIX.

Ports:
- clk24  input  1  system clock, 24 MHz.
- rst_n  input  1  reset, asynchronous, active-low.
- cam_pclk  input  1  camera pixel clock, asynchronous to clk24.
- cam_href  input  1  camera line-valid, active-high.
- cam_vsync  input  1  camera frame sync, active-high pulse between frames.
- cam_d  input  8  camera data byte.
- wr_addr  output  19  frame-buffer write address.
- wr_data  output  4  grayscale pixel.
- wr_en  output  1  one-cycle write strobe.
- frame_done  output  1  one-cycle pulse at the end of each captured frame.
- frame_ovf  output  1  sticky flag: more than H_PIX*V_PIX pixels arrived in the current frame.
- capturing  output  1  high while the FSM is in ACTIVE.

## Operation
- Synchronisers:
  - cam_pclk, cam_href, cam_vsync and cam_d each pass through two flops (s1, s2).
  - cam_pclk and cam_vsync get a third flop (s3).
  - A pclk rise is s2=1, s3=0; a vsync rise or fall is detected the same way.
- The FSM has three states: IDLE, VSYNC and ACTIVE. Reset enters IDLE.
  - IDLE to VSYNC: on a vsync rise. This ensures capture never starts mid-frame.
  - VSYNC to ACTIVE: on a vsync fall. On this transition, pix_cnt is cleared to 0, frame_ovf is cleared and the byte phase is cleared to 0.
  - ACTIVE to VSYNC: on a vsync rise. frame_done pulses in the same cycle.
  - If a vsync event and a pclk rise occur in the same cycle, the vsync event wins and that byte is dropped.
- Byte assembly, ACTIVE only:
  - On a pclk rise with href s2=1, the byte is latched and the phase toggles.
  - While href s2=0, the phase is forced to 0, so every line starts on byte 0.
- Pixel completes on phase 1:
  - If pix_cnt < H_PIX*V_PIX: wr_en=1, wr_addr=pix_cnt and wr_data is the converted pixel, all registered; then pix_cnt increments.
  - Otherwise: wr_en stays 0 and frame_ovf is set. pix_cnt saturates and never wraps.
- Default conversion (YUYV, Y byte first): wr_data = byte0[7:4]; byte1 is discarded.
- Outputs are registered and held between strobes. wr_en and frame_done are single-cycle pulses.
- Reset values: wr_addr=0, wr_data=0, wr_en=0, frame_done=0, frame_ovf=0, capturing=0, pix_cnt=0, phase=0, state=IDLE. All synchroniser flops reset to 0.

## Timing
- Write latency: wr_en is high in the cycle after the 3rd clk24 edge following the first edge that samples cam_pclk high for byte 1.
  - Stages: s1, s2, s3/edge detect, output register.
- Throughput is at most one write per 4 clk24 cycles, given cam_pclk ≤ 12 MHz and two bytes per pixel.
- frame_done is coincident with the exit from ACTIVE. It is never asserted in IDLE, so the first vsync after reset does not produce a pulse.
- If rst_n is asserted mid-frame, all state clears immediately. After release the block waits for a full vsync high-to-low transition before writing; no partial frame is written.

## Configuration
- CAPTURE_RGB565_EN defined: pixels are RGB565 with byte0 = {R5, G6[5:3]} and byte1 = {G6[2:0], B5}.
  - Compute the 7-bit sum y = R5 + G6 + B5; wr_data = y[6:3].
  - Examples: 0xFFFF gives 15, 0x0000 gives 0, 0x07E0 gives 7.
- CAPTURE_RGB565_EN undefined: YUYV mode, wr_data = byte0[7:4].
- Timing is identical in both modes.

## Test plan
- Reset check: hold rst_n low, then release; all outputs read 0. Pulse vsync low to high to low, then drive one line of 4 pixels with bytes 0xA0,0x11,0x50,0x22,0xF0,0x33,0x00,0x44 (YUYV). Expect 4 wr_en strobes: addresses 0, 1, 2, 3 with data 0xA, 0x5, 0xF, 0x0.
- Full frame: 480 lines of 640 pixels, then a vsync rise. Expect exactly 307200 writes, last wr_addr=307199, one frame_done pulse and frame_ovf=0.
- Overflow: a frame with 481 lines. Expect 307200 writes, no writes beyond address 307199 and frame_ovf=1. On the next frame start, frame_ovf returns to 0 and the first write goes to address 0.
- Mid-frame start: release reset while href is already toggling mid-frame. Expect no wr_en and no frame_done until after the next vsync fall; the first write then goes to address 0.
- Mid-line reset: assert rst_n for 2 cycles in the middle of a line. Expect immediate return to reset values, and capture resuming only at the next frame.
- RGB565 build (CAPTURE_RGB565_EN defined): pixels 0xFFFF, 0x0000, 0x07E0, 0xF800 give wr_data 15, 0, 7, 3.
